// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and default frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } tx_state_t;

    localparam int UART_BAUD_DIV      = 434;
    localparam int UART_DATA_BITS     = 8;
    localparam int UART_MAX_DATA_BITS = 9;
    // Sized for the widest legal frame so one counter serves every DATA_BITS choice
    localparam int UART_BIT_CNT_W     = $clog2(UART_MAX_DATA_BITS + 1);

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1, pulses tick on the terminal count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: holding/shift registers, baud timing and frame sequencing.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_en,
    input  logic                 tx_enable,
    input  logic                 tx_sel,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_out,
    output logic                 data_transmitted,
    output logic                 busy
);

    localparam logic [UART_BIT_CNT_W-1:0] LAST_DATA = UART_BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [UART_BIT_CNT_W-1:0] LAST_STOP = UART_BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t                 state;
    tx_state_t                 next_state;
    logic [DATA_BITS-1:0]      hold_reg;
    logic [DATA_BITS-1:0]      shift_reg;
    logic [UART_BIT_CNT_W-1:0] bit_cnt;
    logic                      tx_enable_q;
    logic                      armed;
    logic                      baud_tick;
    logic                      state_chg;
    logic                      start;
    logic                      abort;
    logic                      serial_bit;
`ifdef UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    // armed stays low until tx_enable has been seen low after reset, so an
    // enable still held high across reset release cannot look like a new edge.
    assign start     = (state == IDLE) && tx_enable && !tx_enable_q && armed;
    assign busy      = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign abort     = busy && !tx_enable;
    assign state_chg = (next_state != state);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .reset (reset),
        .clear (state_chg),
        .tick  (baud_tick)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = START;
            START: begin
                if (abort)          next_state = IDLE;
                else if (baud_tick) next_state = DATA;
            end
            DATA: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (baud_tick && (bit_cnt == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (abort)          next_state = IDLE;
                else if (baud_tick) next_state = STOP;
            end
`endif
            STOP: begin
                if (abort)                                 next_state = IDLE;
                else if (baud_tick && (bit_cnt == LAST_STOP)) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        serial_bit = 1'b1;
        case (state)
            START:  serial_bit = 1'b0;
            DATA:   serial_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: serial_bit = parity_bit;
`endif
            default: serial_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            tx_enable_q      <= 1'b0;
            armed            <= 1'b0;
            bit_cnt          <= '0;
            tx_out           <= 1'b1;
            data_transmitted <= 1'b0;
        end else begin
            state       <= next_state;
            tx_enable_q <= tx_enable;
            armed       <= armed | ~tx_enable;
            // bit_cnt indexes data bits in DATA and stop bits in STOP
            if (state_chg) begin
                bit_cnt <= '0;
            end else if (baud_tick && ((state == DATA) || (state == STOP))) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // Registered line; an abort forces idle immediately rather than a cycle late
            tx_out           <= (tx_sel && !abort) ? serial_bit : 1'b1;
            data_transmitted <= (state == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg   <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (load_en) begin
                hold_reg <= tx_data;
            end
            if (start) begin
                shift_reg  <= hold_reg;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^hold_reg;
`endif
            end else if ((state == DATA) && baud_tick) begin
                shift_reg <= shift_reg >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Scoreboard bench for uart_tx_datapath: expected frames queued by stimulus, decoded off tx_out by a monitor.
module tb_uart_tx_datapath;

    localparam int BD = 4;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = 1 + DB + PB + SB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         cut;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic       tx_enable;
    logic       tx_sel;
    logic [7:0] tx_data;
    logic       tx_out;
    logic       data_transmitted;
    logic       busy;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_active  = 0;

    uart_tx_datapath #(
        .BAUD_DIV  (BD),
        .DATA_BITS (DB),
        .STOP_BITS (SB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .tx_enable        (tx_enable),
        .tx_sel           (tx_sel),
        .tx_data          (tx_data),
        .tx_out           (tx_out),
        .data_transmitted (data_transmitted),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p, input bit c);
        exp_t e;
        e.data = d;
        e.par  = p;
        e.cut  = c;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [7:0] d);
        load_en = 1'b1;
        tx_data = d;
        tick(1);
        load_en = 1'b0;
    endtask

    // Returns one cycle after the edge that detects the rising tx_enable
    task automatic start_frame();
        tx_enable = 1'b0;
        tick(1);
        tx_enable = 1'b1;
        tick(1);
    endtask

    // Monitor: decode each frame at mid-bit and time the done pulse from the start-bit fall
    initial begin : monitor
        logic        prev;
        logic [15:0] fb;
        exp_t        e;
        int          off;
        bit          got_dt;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset && prev && !tx_out) begin
                mon_active = 1;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame: got start bit on tx_out, expected idle line");
                    e.data = 8'h00;
                    e.par  = 1'b0;
                    e.cut  = 1;
                end else begin
                    e = exp_q.pop_front();
                end
                if (e.cut) begin
                    got_dt = 0;
                    repeat (4 * NB + 8) begin
                        @(negedge clk);
                        if (data_transmitted) got_dt = 1;
                    end
                    check("cut_no_done_pulse", 32'(got_dt), 32'd0);
                end else begin
                    fb = '0;
                    repeat (2) @(negedge clk);
                    fb[0] = tx_out;
                    for (int i = 1; i < NB; i++) begin
                        repeat (BD) @(negedge clk);
                        fb[i] = tx_out;
                    end
                    check("start_bit", 32'(fb[0]), 32'd0);
                    check("data_bits", 32'(fb[DB:1]), 32'(e.data));
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", 32'(fb[DB+1]), 32'(e.par));
`endif
                    check("stop_bits", 32'(fb[NB-1 -: SB]), 32'({SB{1'b1}}));
                    off = BD * NB - 2;
                    while (!data_transmitted && off < BD * NB + 8) begin
                        @(negedge clk);
                        off++;
                    end
                    check("done_latency", 32'(off), 32'(BD * NB));
                    @(negedge clk);
                    check("done_width", 32'(data_transmitted), 32'd0);
                end
                mon_active = 0;
            end
            prev = tx_out;
        end
    end

    always @(negedge clk) begin
        if (data_transmitted && !mon_active) begin
            miscompares++;
            $display("FAIL stray_done_pulse: got data_transmitted=1, expected 0 outside a frame");
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin : stimulus
        reset     = 1'b0;
        load_en   = 1'b0;
        tx_enable = 1'b0;
        tx_sel    = 1'b0;
        tx_data   = 8'h00;
        tick(3);
        check("reset_tx_out", 32'(tx_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(data_transmitted), 32'd0);
        reset = 1'b1;
        tick(3);

        // Basic frame 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
        load(8'hA5);
        tx_sel = 1'b1;
        push(8'hA5, 1'b0, 0);
        start_frame();
        // Hold enable high well past DONE: no retransmission
        tick(65);
        check("no_retransmit_busy", 32'(busy), 32'd0);
        check("no_retransmit_line", 32'(tx_out), 32'd1);
        push(8'hA5, 1'b0, 0);
        start_frame();
        tick(55);

        // Odd-weight byte: parity bit 1
        load(8'h07);
        push(8'h07, 1'b1, 0);
        start_frame();
        tick(55);

        // Reload mid-frame: in-flight frame keeps the old byte
        load(8'hA5);
        push(8'hA5, 1'b0, 0);
        start_frame();
        tick(10);
        load(8'h3C);
        tick(50);
        push(8'h3C, 1'b0, 0);
        start_frame();
        tick(55);

        // load_en coincident with the start edge: shift gets old value, hold gets new
        load(8'h5A);
        tx_enable = 1'b0;
        tick(1);
        push(8'h5A, 1'b0, 0);
        load_en   = 1'b1;
        tx_data   = 8'hC3;
        tx_enable = 1'b1;
        tick(1);
        load_en = 1'b0;
        tick(55);
        push(8'hC3, 1'b0, 0);
        start_frame();
        tick(55);

        // Abort during data bit 3
        load(8'h96);
        push(8'h96, 1'b0, 1);
        start_frame();
        tick(17);
        check("abort_busy_before", 32'(busy), 32'd1);
        tx_enable = 1'b0;
        tick(1);
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_tx_out_after", 32'(tx_out), 32'd1);
        tick(60);

        // Reset asserted during STOP, released with tx_enable still high
        load(8'hFF);
        push(8'hFF, 1'b0, 1);
        start_frame();
        tick(37);
        check("stop_busy_before_reset", 32'(busy), 32'd1);
        check("stop_line_high", 32'(tx_out), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_tx_out", 32'(tx_out), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(data_transmitted), 32'd0);
        tick(3);
        reset = 1'b1;
        tick(30);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_tx_out", 32'(tx_out), 32'd1);

        for (int i = 0; i < 300 && (exp_q.size() != 0 || mon_active); i++) tick(1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
